// File: rtl/fp_mult_iter.sv
// Iterative IEEE-754-style multiplier: radix-2 shift-add significand product,
// RNE rounding, flush-to-zero range handling and valid/ready on both sides.
module fp_mult_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [3:0]               out_flags
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;
    localparam int P_W   = 2 * SIG_W;
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAN_W);
    localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(MAN_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Operand fields
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             is_special;
    logic [W-1:0]     spec_result;
    logic [3:0]       spec_flags;
    logic             accept;
    logic             res_sign;
    logic signed [E_W-1:0] exp_in;

    // Datapath registers
    logic                  sign_q;
    logic                  special_q;
    logic signed [E_W-1:0] exp_q;
    logic [SIG_W-1:0]      mcand;
    logic [SIG_W-1:0]      mplier;
    logic [P_W-1:0]        acc;
    logic [CNT_W-1:0]      cnt;
    logic [MAN_W-1:0]      frac_q;
    logic                  guard_q;
    logic                  sticky_q;

    // Combinational step results
    logic [SIG_W:0]        add_sum;
    logic [MAN_W-1:0]      norm_frac;
    logic                  norm_guard;
    logic                  norm_sticky;
    logic                  rnd_inc;
    logic [MAN_W:0]        frac_sum;
    logic                  rnd_carry;
    logic [MAN_W-1:0]      rnd_frac;
    logic signed [E_W-1:0] rnd_exp;
    logic                  inexact;
    logic [W-1:0]          rnd_result;
    logic [3:0]            rnd_flags;

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    assign a_sign   = in_a[W-1];
    assign b_sign   = in_b[W-1];
    assign a_exp    = in_a[W-2:MAN_W];
    assign b_exp    = in_b[W-2:MAN_W];
    assign a_frac   = in_a[MAN_W-1:0];
    assign b_frac   = in_b[MAN_W-1:0];
    assign res_sign = a_sign ^ b_sign;
    assign exp_in   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(E_W'(BIAS));

    always_comb begin
        a_nan  = (a_exp == {EXP_W{1'b1}}) && (a_frac != '0);
        b_nan  = (b_exp == {EXP_W{1'b1}}) && (b_frac != '0);
        a_inf  = (a_exp == {EXP_W{1'b1}}) && (a_frac == '0);
        b_inf  = (b_exp == {EXP_W{1'b1}}) && (b_frac == '0);
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);

        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flags  = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_result = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_result = {res_sign, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // Carry of the upper-half add becomes the new MSB after the right shift.
    assign add_sum = {1'b0, acc[P_W-1:SIG_W]} + (mplier[0] ? {1'b0, mcand} : '0);

    always_comb begin
        if (acc[P_W-1]) begin
            norm_frac   = acc[P_W-2:SIG_W];
            norm_guard  = acc[SIG_W-1];
            norm_sticky = |acc[SIG_W-2:0];
        end else begin
            norm_frac   = acc[P_W-3:SIG_W-1];
            norm_guard  = acc[SIG_W-2];
            norm_sticky = |acc[SIG_W-3:0];
        end
    end

    // Hidden bit is always set after NORM, so a fraction carry means 2.0 -> 1.0.
    always_comb begin
        rnd_inc   = guard_q & (sticky_q | frac_q[0]);
        frac_sum  = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
        rnd_carry = frac_sum[MAN_W];
        rnd_frac  = rnd_carry ? '0 : frac_sum[MAN_W-1:0];
        rnd_exp   = exp_q + $signed({{(E_W-1){1'b0}}, rnd_carry});
        inexact   = guard_q | sticky_q;

        rnd_result = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        rnd_flags  = {3'b000, inexact};
        if (rnd_exp >= EXP_MAX) begin
            rnd_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags  = 4'b0101;
        end else if (rnd_exp <= EXP_ZERO) begin
            rnd_result = {sign_q, {(W-1){1'b0}}};
            rnd_flags  = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Specials pass through ROUND so every result spends a cycle before DONE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = is_special ? S_ROUND : S_MUL;
            S_MUL:   if (cnt == CNT_LAST) state_next = S_NORM;
            S_NORM:  state_next = S_ROUND;
            S_ROUND: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            exp_q      <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            frac_q     <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_q    <= res_sign;
                        special_q <= is_special;
                        exp_q     <= exp_in;
                        mcand     <= {1'b1, a_frac};
                        mplier    <= {1'b1, b_frac};
                        acc       <= '0;
                        cnt       <= '0;
                        if (is_special) begin
                            out_result <= spec_result;
                            out_flags  <= spec_flags;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= {add_sum, acc[SIG_W-1:1]};
                    mplier <= mplier >> 1;
                    if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                end
                S_NORM: begin
                    frac_q   <= norm_frac;
                    guard_q  <= norm_guard;
                    sticky_q <= norm_sticky;
                    exp_q    <= exp_q + $signed({{(E_W-1){1'b0}}, acc[P_W-1]});
                end
                S_ROUND: begin
                    if (!special_q) begin
                        out_result <= rnd_result;
                        out_flags  <= rnd_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed self-checking bench for fp_mult_iter (FP32): products, rounding,
// range limits, specials, backpressure and mid-operation reset.
module tb_fp_mult_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int errors = 0;
    int checks = 0;
    int lat;

    fp_mult_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; the next rising edge is the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        check({tag, ".ready_before"}, {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h12345678;
        check({tag, ".ready_after"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic await(input string tag, input int exp_lat,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, out_result, exp_res);
        check({tag, ".flags"}, {28'd0, out_flags}, {28'd0, exp_flags});
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".valid_cleared"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                         input int exp_lat, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        issue(a, b, tag);
        await(tag, exp_lat, exp_res, exp_flags);
        take(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.out_result", out_result, 32'd0);
        check("reset.out_flags", {28'd0, out_flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);

        do_op(32'h3FC00000, 32'h40000000, "basic_1p5x2", 26, 32'h40400000, 4'b0000);
        do_op(32'h3F800001, 32'h3F800001, "round_sticky", 26, 32'h3F800002, 4'b0001);
        do_op(32'h3FFFFFFF, 32'h3FFFFFFF, "round_msb", 26, 32'h407FFFFE, 4'b0001);
        do_op(32'h7F7FFFFF, 32'h40000000, "overflow", 26, 32'h7F800000, 4'b0101);
        do_op(32'h00800000, 32'h3F000000, "underflow_pos", 26, 32'h00000000, 4'b0011);
        do_op(32'h80800000, 32'h3F000000, "underflow_neg", 26, 32'h80000000, 4'b0011);
        do_op(32'h7F800000, 32'h00000000, "inf_x_zero", 1, 32'h7FC00000, 4'b1000);
        do_op(32'hFF800000, 32'h40000000, "neginf_x_two", 1, 32'hFF800000, 4'b0000);
        do_op(32'h7FC00001, 32'h3F800000, "nan_in", 1, 32'h7FC00000, 4'b1000);
        do_op(32'hC0400000, 32'h00000000, "negthree_x_zero", 1, 32'h80000000, 4'b0000);

        // Backpressure: result held for 5 cycles while a second request is offered.
        issue(32'h3FC00000, 32'h40000000, "bp");
        await("bp", 26, 32'h40400000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_a     = 32'h40400000;
                in_b     = 32'h40400000;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp.hold_result", out_result, 32'h40400000);
            check("bp.hold_flags", {28'd0, out_flags}, 32'd0);
            check("bp.hold_ready", {31'd0, in_ready}, 32'd0);
        end
        take("bp");
        do_op(32'h40400000, 32'h40400000, "bp_second", 26, 32'h41100000, 4'b0000);

        // Reset asserted 10 cycles into the iteration phase.
        issue(32'h3FC00000, 32'h40000000, "rst_mid");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid.out_result", out_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("rst_mid.no_output", {31'd0, out_valid}, 32'd0);
        do_op(32'h40400000, 32'h40400000, "after_rst", 26, 32'h41100000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
